// File: rtl/uart_tx_sink.sv
// uart_tx_sink
//   Receiving end of the CPU's serial Tx line. Decodes 8N1 frames (or 8E1 when
//   UART_SINK_PARITY_EN is defined) into bytes. The bytes are held in a
//   first-word-fall-through FIFO, which a consumer drains over a valid/ready port.
//
// Configuration macro: UART_SINK_PARITY_EN
//   defined     -> 8E1 framing with an even parity bit; parity_err is live
//   not defined -> 8N1 framing; parity_err is tied to 0
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   dout        byte at the FIFO head (0 when empty)
//   dout_valid  FIFO not empty
//   dout_ready  consumer accepts dout; pop = dout_valid && dout_ready
//   frame_err   1-cycle pulse: stop bit sampled low
//   parity_err  1-cycle pulse: parity mismatch
//   overflow    1-cycle pulse: good byte dropped, FIFO full
//   busy        receiver FSM not in IDLE
module uart_tx_sink #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overflow,
    output logic       busy
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, RECOVER
`ifdef UART_SINK_PARITY_EN
        , PARITY
`endif
    } state_t;

    // Two-flop synchronizer. It resets to the idle level, so reset does not
    // look like a start bit.
    logic sync1, rxs;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          push, ferr_n, perr_n;
`ifdef UART_SINK_PARITY_EN
    logic          bad, bad_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_SINK_PARITY_EN
            bad     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
`ifdef UART_SINK_PARITY_EN
            bad     <= bad_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        bit_n   = bit_idx;
        sh_n    = shreg;
        push    = 1'b0;
        ferr_n  = 1'b0;
        perr_n  = 1'b0;
`ifdef UART_SINK_PARITY_EN
        bad_n   = bad;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
`ifdef UART_SINK_PARITY_EN
                bad_n = 1'b0;
`endif
                if (!rxs) state_n = START;
            end
            START: begin
                // Mid-bit check. A line that is high again was a glitch.
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    bit_n = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_n = '0;
                    sh_n  = {rxs, shreg[7:1]};
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_SINK_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_SINK_PARITY_EN
            PARITY: begin
                // Even parity: the parity bit equals the XOR of the data bits.
                if (cnt == BIT_M1) begin
                    cnt_n   = '0;
                    bad_n   = (rxs != ^shreg);
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_n = '0;
                    if (rxs) begin
                        state_n = IDLE;
`ifdef UART_SINK_PARITY_EN
                        if (bad) perr_n = 1'b1;
                        else     push   = 1'b1;
`else
                        push = 1'b1;
`endif
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = RECOVER;
                    end
                end
            end
            RECOVER: begin
                // Hold off until the line idles so a break yields no frames.
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FIFO with pointers one bit wider than the address (full vs empty)
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = dout_valid && dout_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            frame_err <= ferr_n;
            overflow  <= push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
    end

`ifdef UART_SINK_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= perr_n;
    end
`else
    assign parity_err = 1'b0;
`endif

    // The storage array is not reset, so mask the head byte while empty.
    assign dout_valid = !empty;
    assign dout       = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sink.sv
module tb_uart_tx_sink;
    localparam int CPB = 8;
`ifdef UART_SINK_PARITY_EN
    localparam int FB      = 11;
    localparam int EXP_LAT = 87;   // 2 sync + 4 half + 80 + 1
`else
    localparam int FB      = 10;
    localparam int EXP_LAT = 79;   // 2 sync + 4 half + 72 + 1
`endif
    localparam int POP_OFF = EXP_LAT - 1;  // cycle holding the push edge

    logic       clk = 1'b0;
    logic       rst_n, rx, dout_ready;
    logic [7:0] dout;
    logic       dout_valid, frame_err, parity_err, overflow, busy;

    uart_tx_sink #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .frame_err(frame_err), .parity_err(parity_err),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor sampling on the falling edge
    int         fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
    int         busy_rises = 0, busy_rise_cyc = 0, valid_rise_cyc = 0;
    int         vrun = 0, last_vrun = 0;
    logic       prev_busy = 1'b0, prev_valid = 1'b0;
    logic [7:0] pops[$];
    int         pop_cyc[$];

    always @(negedge clk) begin
        fe_cnt <= fe_cnt + int'(frame_err);
        pe_cnt <= pe_cnt + int'(parity_err);
        ov_cnt <= ov_cnt + int'(overflow);
        prev_busy  <= busy;
        prev_valid <= dout_valid;
        if (busy && !prev_busy) begin
            busy_rises    <= busy_rises + 1;
            busy_rise_cyc <= cyc;
        end
        if (dout_valid && !prev_valid) valid_rise_cyc <= cyc;
        vrun <= dout_valid ? vrun + 1 : 0;
        if (!dout_valid && vrun != 0) last_vrun <= vrun;
        if (dout_valid && dout_ready) begin
            pops.push_back(dout);
            pop_cyc.push_back(cyc);
        end
    end

    int n_assert = 0, n_fail = 0;
    int fall_cyc = 0;
    logic snap_valid, snap_busy;
    logic [7:0] snap_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    // One frame, CPB cycles per bit. pop_off >= 0 drives dout_ready high for
    // that single frame cycle only. rst_off >= 0 pulses rst_n for one cycle.
    task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb,
                              input int pop_off, input int rst_off);
        logic [10:0] frm;
`ifdef UART_SINK_PARITY_EN
        frm = {stopb, parb, d, 1'b0};
`else
        frm = {parb, stopb, d, 1'b0};
`endif
        fall_cyc = cyc;
        for (int k = 0; k < FB * CPB; k++) begin
            if (rst_off >= 0 && k == rst_off + 1) begin
                snap_valid = dout_valid;
                snap_busy  = busy;
                snap_dout  = dout;
                rst_n = 1'b1;
            end
            if (rst_off >= 0 && k == rst_off) rst_n = 1'b0;
            rx = frm[k / CPB];
            if (pop_off >= 0) dout_ready = (k == pop_off);
            wait_clk();
        end
    endtask

    initial begin
        int np, fe0, ov0, pe0, b0;
        rst_n = 1'b0; rx = 1'b1; dout_ready = 1'b0;
        repeat (3) wait_clk();
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_errs", 32'({frame_err, parity_err, overflow}), 0);
        rst_n = 1'b1;
        repeat (5) wait_clk();

        // 1: basic frame
        dout_ready = 1'b1;
        np = pops.size(); fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        send_frame(8'h55, 1'b1, ^8'h55, -1, -1);
        repeat (10) wait_clk();
        chk("t1_npop", 32'(pops.size() - np), 1);
        if (pops.size() > np) chk("t1_byte", 32'(pops[np]), 32'h55);
        chk("t1_latency", 32'(valid_rise_cyc - fall_cyc), 32'(EXP_LAT));
        chk("t1_valid_len", 32'(last_vrun), 1);
        chk("t1_busy_rise", 32'(busy_rise_cyc - fall_cyc), 3);
        chk("t1_no_err", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)), 0);
        chk("t1_busy_end", 32'(busy), 0);

        // 2a: 3-cycle glitch
        b0 = busy_rises; np = pops.size();
        rx = 1'b0;
        repeat (3) wait_clk();
        rx = 1'b1;
        repeat (20) wait_clk();
        chk("t2_glitch_busy", 32'(busy_rises - b0), 1);
        chk("t2_glitch_idle", 32'(busy), 0);
        chk("t2_glitch_nopop", 32'(pops.size() - np), 0);
        chk("t2_glitch_noerr", 32'(fe_cnt - fe0), 0);

        // 2b: framing error, line held low 20 more cycles
        send_frame(8'hA3, 1'b0, ^8'hA3, -1, -1);
        repeat (20) wait_clk();
        chk("t2_recover_busy", 32'(busy), 1);
        rx = 1'b1;
        repeat (6) wait_clk();
        chk("t2_frame_err", 32'(fe_cnt - fe0), 1);
        chk("t2_idle", 32'(busy), 0);
        chk("t2_empty", 32'(dout_valid), 0);
        chk("t2_nopop", 32'(pops.size() - np), 0);

        // 3: overflow on the 5th back-to-back frame
        dout_ready = 1'b0; ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, ^8'(i), -1, -1);
        repeat (4) wait_clk();
        chk("t3_overflow", 32'(ov_cnt - ov0), 1);
        chk("t3_valid", 32'(dout_valid), 1);
        chk("t3_head", 32'(dout), 32'h01);
        np = pops.size();
        dout_ready = 1'b1;
        repeat (6) wait_clk();
        dout_ready = 1'b0;
        chk("t3_npop", 32'(pops.size() - np), 4);
        if (pops.size() >= np + 4) begin
            for (int i = 0; i < 4; i++) chk("t3_drain", 32'(pops[np + i]), 32'(i + 1));
            chk("t3_consec", 32'(pop_cyc[np + 3] - pop_cyc[np]), 3);
        end
        chk("t3_empty", 32'(dout_valid), 0);

        // 4: full FIFO, pop on the exact push cycle
        send_frame(8'h11, 1'b1, ^8'h11, -1, -1);
        send_frame(8'h22, 1'b1, ^8'h22, -1, -1);
        send_frame(8'h33, 1'b1, ^8'h33, -1, -1);
        send_frame(8'h44, 1'b1, ^8'h44, -1, -1);
        np = pops.size(); ov0 = ov_cnt;
        send_frame(8'h66, 1'b1, ^8'h66, POP_OFF, -1);
        repeat (4) wait_clk();
        chk("t4_no_overflow", 32'(ov_cnt - ov0), 0);
        dout_ready = 1'b1;
        repeat (6) wait_clk();
        dout_ready = 1'b0;
        chk("t4_npop", 32'(pops.size() - np), 5);
        if (pops.size() >= np + 5) begin
            chk("t4_pop0", 32'(pops[np]), 32'h11);
            chk("t4_pop1", 32'(pops[np + 1]), 32'h22);
            chk("t4_pop3", 32'(pops[np + 3]), 32'h44);
            chk("t4_tail", 32'(pops[np + 4]), 32'h66);
        end

        // 5: reset at data bit 4 with 2 entries held
        send_frame(8'hA1, 1'b1, ^8'hA1, -1, -1);
        send_frame(8'hB2, 1'b1, ^8'hB2, -1, -1);
        chk("t5_pre_valid", 32'(dout_valid), 1);
        np = pops.size(); fe0 = fe_cnt;
        send_frame(8'hF5, 1'b1, ^8'hF5, -1, 44);
        chk("t5_rst_valid", 32'(snap_valid), 0);
        chk("t5_rst_busy", 32'(snap_busy), 0);
        chk("t5_rst_dout", 32'(snap_dout), 0);
        repeat (30) wait_clk();
        chk("t5_no_byte", 32'(dout_valid), 0);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_noerr", 32'(fe_cnt - fe0), 0);
        dout_ready = 1'b1;
        send_frame(8'h3C, 1'b1, ^8'h3C, -1, -1);
        repeat (5) wait_clk();
        chk("t5_npop", 32'(pops.size() - np), 1);
        if (pops.size() > np) chk("t5_after", 32'(pops[np]), 32'h3C);

`ifdef UART_SINK_PARITY_EN
        // 6: parity
        np = pops.size(); pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, -1, -1);
        repeat (5) wait_clk();
        chk("t6_good_pop", 32'(pops.size() - np), 1);
        chk("t6_good_noerr", 32'(pe_cnt - pe0), 0);
        np = pops.size();
        send_frame(8'h07, 1'b1, 1'b0, -1, -1);
        repeat (5) wait_clk();
        chk("t6_parity_err", 32'(pe_cnt - pe0), 1);
        chk("t6_bad_nopop", 32'(pops.size() - np), 0);
`else
        chk("t6_parity_tied", 32'(pe_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_sink.md
# uart_tx_sink

Simulation-side UART receiver attached to the CPU top's `Tx` pin; it is the receiving end of the core's serial output. It decodes 8N1 frames, or 8E1 with parity, into bytes and buffers them in a small first-word-fall-through FIFO. A bench or host model drains that FIFO through a valid/ready port. The block is synthesizable so the same sink can sit on an FPGA loopback.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per UART bit; legal values are ≥ 4.
- `FIFO_DEPTH`, default 8: byte FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx`  in  1  serial line, connected to the CPU `Tx`; idle level is high; asynchronous to `clk`.
- `dout`  out  8  byte at the FIFO head.
- `dout_valid`  out  1  FIFO not empty.
- `dout_ready`  in  1  consumer accepts `dout`; a pop occurs when `dout_valid && dout_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 unless `UART_SINK_PARITY_EN` is defined.
- `overflow`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.
- `busy`  out  1  receiver FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops, both reset to 1. All FSM logic uses the synchronized value `rxs`.
- **Bit counter:** counter width is `$clog2(CLK_PER_BIT)`. `HALF = CLK_PER_BIT/2`, truncated.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP, RECOVER.
- **IDLE:** `rxs == 0` → START, counter cleared.
- **START:** count to `HALF-1`, then sample.
  - `rxs == 1` is a glitch → IDLE, nothing reported.
  - Otherwise → DATA, bit index 0, counter cleared.
- **DATA:** sample every `CLK_PER_BIT` cycles, LSB first, shifting into an 8-bit register. After bit 7 → PARITY (with macro) or STOP.
- **PARITY:** after one bit time, sample; the expected value is even parity over the 8 data bits. A mismatch sets an internal bad flag → STOP.
- **STOP:** after one bit time, sample.
  - `rxs == 1` and the bad flag is clear → push the byte → IDLE.
  - `rxs == 1` and the bad flag is set → pulse `parity_err`, discard the byte → IDLE.
  - `rxs == 0` → pulse `frame_err`, discard the byte → RECOVER.
- **RECOVER:** wait for `rxs == 1` → IDLE. This prevents a break condition from producing spurious frames.
- **FIFO:** `FIFO_DEPTH` entries, with read/write pointers one bit wider than the address to separate full from empty.
  - Push while full with no pop in the same cycle → byte dropped, `overflow` pulses, FIFO unchanged.
  - Push while full with a simultaneous pop → both happen; no overflow.
  - Push and pop together at any other occupancy → occupancy unchanged.
- **Reset:** `rst_n == 0` at any point, including mid-frame, returns the FSM to IDLE and empties the FIFO. All outputs go low: `dout = 0`, `dout_valid`, `frame_err`, `parity_err`, `overflow`, `busy` all 0. The synchronizer flops are set to 1.

## Timing
- Let cycle 0 be the first cycle in which `rxs` is seen low in IDLE. That is 2 cycles after `rx` falls, from synchronizer delay.
- Sample points, counted from cycle 0:
  - start bit: `HALF`
  - data bit i: `HALF + (i+1)*CLK_PER_BIT`
  - parity bit: `HALF + 9*CLK_PER_BIT`
  - stop bit: `HALF + 9*CLK_PER_BIT`, or `+10*CLK_PER_BIT` with parity
- The push is registered at the stop-sample edge. `dout_valid` rises and `dout` is valid on the next cycle.
- `frame_err`, `parity_err` and `overflow` are high for exactly the one cycle after the stop-sample edge.
- `busy` is high from cycle 1 until the cycle after the FSM returns to IDLE.
- Back-to-back frames are supported. A new start bit may begin immediately after the stop sample, because the FSM is back in IDLE within half a bit time.
- `dout` and `dout_valid` depend only on registers; there is no combinational path from `dout_ready`.

## Configuration
- `UART_SINK_PARITY_EN` defined:
  - the PARITY state is compiled in, giving 8E1 frames of 11 bits;
  - `parity_err` is live.
- `UART_SINK_PARITY_EN` not defined:
  - 8N1 frames of 10 bits;
  - there is no PARITY state, no parity logic, and `parity_err` is constant 0.

## Test plan
All scenarios use `CLK_PER_BIT=8` and `FIFO_DEPTH=4`.
1. **Basic frame:** 8N1 frame for 0x55 with `dout_ready=1` → `dout=0x55`, `dout_valid` high for 1 cycle, 2+4+72+1 cycles after `rx` falls; no error pulses.
2. **Glitch and framing error:**
   - `rx` pulled low for 3 cycles only → `busy` pulses and returns to IDLE; no byte, no error.
   - Frame for 0xA3 with stop bit 0, holding `rx` low for 20 more cycles → `frame_err` pulses once, FIFO stays empty, `busy` stays high until `rx` returns high.
3. **Overflow:** 5 back-to-back frames 0x01..0x05 with `dout_ready=0` → 4 entries held; `overflow` pulses on the 5th. Then raising `dout_ready` drains 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
4. **Full with simultaneous pop:** FIFO full; a pop on the exact push cycle of 0x66 → no overflow; 0x66 ends up at the tail.
5. **Reset mid-frame:** `rst_n` low for 1 cycle at data bit 4 while the FIFO holds 2 entries → the next cycle shows `dout_valid=0` and `busy=0`. The remainder of the interrupted frame's bits do not produce a byte unless a valid falling edge follows.
6. **Parity (`UART_SINK_PARITY_EN` defined):**
   - 0x07 with parity bit 1 → accepted.
   - 0x07 with parity bit 0 → `parity_err` pulses once; no push.
